// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: shares the instruction memory port between the program loader and PC-driven fetch
module imem_fetch_ctrl #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_start,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [31:0]           ld_data,
    input  logic                  ld_last,
    input  logic                  run_start,
    input  logic                  br_valid,
    input  logic [DEPTH_LOG2+1:0] br_target,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DEPTH_LOG2+1:0] if_pc,
    output logic [31:0]           if_instr,
    output logic [DEPTH_LOG2+1:0] mem_addr,
    output logic                  mem_we,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  loading,
    output logic [DEPTH_LOG2:0]   words_loaded
);
    localparam int AW = DEPTH_LOG2 + 2;

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                state;
    logic [AW-1:0]         pc;
    logic [DEPTH_LOG2-1:0] cnt;
    logic                  accept;
    logic                  fire;
    logic                  load_done;

    assign ld_ready  = state == LOAD;
    assign loading   = state == LOAD;
    assign accept    = ld_ready & ld_valid;
    assign load_done = accept & (ld_last | (&cnt));
    assign fire      = !if_valid | if_ready;
    assign mem_we    = accept;
    assign mem_wdata = ld_data;
    assign mem_addr  = state == LOAD ? {cnt, 2'b00} : state == RUN ? pc : '0;

    // Sequencer: loader restart beats redirect, redirect beats fetch; fetch stage stalls on backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= '0;
            cnt          <= '0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            words_loaded <= '0;
        end else if (ld_start) begin
            state        <= LOAD;
            cnt          <= '0;
            words_loaded <= '0;
            if_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        cnt          <= cnt + 1'b1;
                        words_loaded <= words_loaded + 1'b1;
                        if (load_done) begin
                            state <= RUN;
                            pc    <= '0;
                            cnt   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (br_valid) begin
                        pc       <= br_target & ~AW'(3);
                        if_valid <= 1'b0;
                    end else if (fire) begin
                        if_instr <= mem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        pc       <= pc + AW'(4);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized scoreboard bench for the instruction fetch sequencer
module tb_imem_fetch_ctrl;
    logic        clk = 0, rst_n = 0;
    logic        ld_start = 0, ld_valid = 0, ld_last = 0, run_start = 0, br_valid = 0, if_ready = 0;
    logic [31:0] ld_data = 0;
    logic [7:0]  br_target = 0;
    logic        ld_ready, if_valid, mem_we, loading;
    logic [7:0]  if_pc, mem_addr;
    logic [31:0] if_instr, mem_wdata, mem_rdata;
    logic [6:0]  words_loaded;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [39:0] fq [$];
    logic [39:0] wq [$];
    logic [39:0] me;
    int          checks = 0, errors = 0, fetched = 0;

    imem_fetch_ctrl #(.DEPTH_LOG2(6)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_data(ld_data), .ld_last(ld_last), .run_start(run_start), .br_valid(br_valid),
        .br_target(br_target), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .loading(loading), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Instruction memory: combinational read, synchronous write
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected accepted-instruction stream from a start address: sequential words with 8-bit wrap
    task automatic push_stream(input logic [7:0] start);
        logic [7:0] a;
        fq.delete();
        for (int i = 0; i < 256; i++) begin
            a = start + 8'(4 * i);
            fq.push_back({a, ref_mem[a[7:2]]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n, input bit use_last, input bit fixed);
        for (int k = 0; k < n; k++) begin
            logic [31:0] d;
            repeat ($urandom_range(0, 2)) tick();
            d = (fixed && k == 0) ? 32'h00007033 : (fixed && k == n - 1) ? 32'h03002603 : $urandom;
            ld_valid = 1;
            ld_data  = d;
            ld_last  = use_last && k == n - 1;
            ref_mem[k] = d;
            wq.push_back({8'(k * 4), d});
            if (k == n - 1 && (use_last || n == 64)) push_stream(8'h00);
            tick();
            ld_valid = 0;
            ld_last  = 0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_if_pc"}, 32'(if_pc), 32'd0);
        check({tag, "_if_instr"}, if_instr, 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
        check({tag, "_loading"}, 32'(loading), 32'd0);
        check({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    endtask

    // Monitor: pops expected writes on mem_we and expected instructions on each consumed fetch
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h expected no write", mem_addr);
            end else begin
                me = wq.pop_front();
                check("write_addr", 32'(mem_addr), 32'(me[39:32]));
                check("write_data", mem_wdata, me[31:0]);
            end
        end
        if (rst_n && if_valid && if_ready && !br_valid && !ld_start) begin
            fetched++;
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc %h expected no instruction", if_pc);
            end else begin
                me = fq.pop_front();
                check("fetch_pc", 32'(if_pc), 32'(me[39:32]));
                check("fetch_instr", if_instr, me[31:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  sp, sa;
        logic [31:0] si;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        tick();
        ld_start = 1;
        tick();
        ld_start = 0;
        check("load_entry_loading", 32'(loading), 32'd1);
        check("load_entry_ld_ready", 32'(ld_ready), 32'd1);
        if_ready = 1;
        load_words(20, 1, 1);
        check("run_entry_loading", 32'(loading), 32'd0);
        check("run_entry_words", 32'(words_loaded), 32'd20);
        check("run_entry_bubble", 32'(if_valid), 32'd0);
        tick();
        check("first_valid", 32'(if_valid), 32'd1);
        check("first_pc", 32'(if_pc), 32'd0);
        check("first_instr", if_instr, 32'h00007033);
        repeat (70) begin
            sp = if_pc;
            tick();
            check("throughput_valid", 32'(if_valid), 32'd1);
            check("throughput_step", 32'(if_pc), 32'(8'(sp + 8'd4)));
        end
        for (int i = 0; i < 100 && !(if_valid && if_pc == 8'h10); i++) tick();
        check("stall_find", 32'(if_pc), 32'h10);
        if_ready = 0;
        sp = if_pc;
        si = if_instr;
        sa = mem_addr;
        check("stall_pc_ahead", 32'(sa), 32'h14);
        repeat (5) begin
            tick();
            check("stall_if_pc", 32'(if_pc), 32'(sp));
            check("stall_if_instr", if_instr, si);
            check("stall_pc", 32'(mem_addr), 32'(sa));
        end
        if_ready = 1;
        tick();
        check("stall_release", 32'(if_pc), 32'h14);
        for (int i = 0; i < 100 && !(if_valid && if_pc == 8'h20); i++) tick();
        check("redirect_find", 32'(if_pc), 32'h20);
        if_ready = 0;
        tick();
        tick();
        br_valid  = 1;
        br_target = 8'h4B;
        push_stream(8'h48);
        tick();
        br_valid = 0;
        if_ready = 1;
        check("redirect_flush", 32'(if_valid), 32'd0);
        tick();
        check("redirect_valid", 32'(if_valid), 32'd1);
        check("redirect_pc", 32'(if_pc), 32'h48);
        check("redirect_instr", if_instr, ref_mem[18]);
        repeat (300) begin
            if_ready  = $urandom_range(0, 3) != 0;
            run_start = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 11) == 0) begin
                br_valid  = 1;
                br_target = 8'($urandom);
                push_stream(br_target & 8'hFC);
            end
            tick();
            br_valid  = 0;
            run_start = 0;
        end
        ld_start  = 1;
        br_valid  = 1;
        br_target = 8'h80;
        fq.delete();
        tick();
        ld_start = 0;
        br_valid = 0;
        if_ready = 1;
        check("ldbr_flush", 32'(if_valid), 32'd0);
        check("ldbr_loading", 32'(loading), 32'd1);
        check("ldbr_words", 32'(words_loaded), 32'd0);
        load_words(64, 0, 0);
        check("full_words", 32'(words_loaded), 32'd64);
        check("full_loading", 32'(loading), 32'd0);
        check("full_bubble", 32'(if_valid), 32'd0);
        tick();
        check("full_first_valid", 32'(if_valid), 32'd1);
        check("full_first_pc", 32'(if_pc), 32'd0);
        repeat (10) tick();
        ld_start = 1;
        fq.delete();
        tick();
        ld_start = 0;
        load_words(10, 0, 0);
        check("partial_words", 32'(words_loaded), 32'd10);
        #2;
        rst_n = 0;
        fq.delete();
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1;
        tick();
        check("idle_after_reset", 32'(loading), 32'd0);
        run_start = 1;
        push_stream(8'h00);
        tick();
        run_start = 0;
        check("restart_bubble", 32'(if_valid), 32'd0);
        tick();
        check("restart_valid", 32'(if_valid), 32'd1);
        check("restart_pc", 32'(if_pc), 32'd0);
        check("restart_instr", if_instr, ref_mem[0]);
        repeat (20) tick();
        check("write_queue_drained", 32'(wq.size()), 32'd0);
        check("fetch_count_min", 32'(fetched >= 150), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
